// File: rtl/imem_loader.sv
// Instruction RAM with a byte-stream image loader; holds the core in reset
// until a complete image is present, then serves instructions combinationally.
module imem_loader #(
    parameter int          ADDR_SIZE = 6,
    parameter logic [31:0] FILL_WORD = 32'h0000000D
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [7:0]           load_data,
    input  logic                 load_last,
    input  logic                 reload,
    input  logic [31:0]          raddr,
    output logic [31:0]          instr,
    output logic                 core_reset,
    output logic                 loaded,
    output logic                 overflow,
    output logic [ADDR_SIZE:0]   word_count,
    output logic [1:0]           fsm_state
);

    // Handshake: a byte transfers on a rising edge where load_valid && load_ready;
    // the byte must stay stable while load_valid is high and load_ready is low.
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        OVF  = 2'd2
    } state_t;

    localparam int                DEPTH      = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] FULL_COUNT = (ADDR_SIZE + 1)'(DEPTH);

    state_t               state, state_n;
    logic [1:0]           byte_idx, byte_idx_n;
    logic [23:0]          asm_reg, asm_n;
    logic [ADDR_SIZE:0]   wc, wc_n;
    logic                 core_reset_q, core_reset_n;
    logic [DEPTH-1:0]     valid_bits;
    logic [31:0]          mem [DEPTH];

    logic                 clear;
    logic                 accept;
    logic                 wr_en;
    logic [31:0]          merged;
    logic [ADDR_SIZE-1:0] wr_idx;
    logic [ADDR_SIZE-1:0] rd_idx;
    logic                 rd_in_range;

    assign clear  = reset || reload;
    assign accept = load_valid && (state == LOAD);
    assign wr_idx = wc[ADDR_SIZE-1:0];

    // Current byte merged into the partially assembled word; upper bytes stay 0.
    always_comb begin
        merged = 32'h0;
        case (byte_idx)
            2'd0:    merged = {24'h0, load_data};
            2'd1:    merged = {16'h0, load_data, asm_reg[7:0]};
            2'd2:    merged = {8'h0, load_data, asm_reg[15:0]};
            default: merged = {load_data, asm_reg};
        endcase
    end

    always_comb begin
        state_n      = state;
        byte_idx_n   = byte_idx;
        asm_n        = asm_reg;
        wc_n         = wc;
        core_reset_n = (state != RUN);
        wr_en        = 1'b0;
        if (clear) begin
            state_n      = LOAD;
            byte_idx_n   = 2'd0;
            asm_n        = 24'h0;
            wc_n         = '0;
            core_reset_n = 1'b1;
        end else if (accept) begin
            if (wc == FULL_COUNT) begin
                // Image too large: drop the byte and park until reload/reset.
                state_n = OVF;
            end else if (byte_idx == 2'd3 || load_last) begin
                wr_en      = 1'b1;
                wc_n       = wc + (ADDR_SIZE + 1)'(1);
                byte_idx_n = 2'd0;
                asm_n      = 24'h0;
                if (load_last) begin
                    state_n = RUN;
                end
            end else begin
                byte_idx_n = byte_idx + 2'd1;
                asm_n      = merged[23:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= LOAD;
            byte_idx     <= 2'd0;
            asm_reg      <= 24'h0;
            wc           <= '0;
            core_reset_q <= 1'b1;
        end else begin
            state        <= state_n;
            byte_idx     <= byte_idx_n;
            asm_reg      <= asm_n;
            wc           <= wc_n;
            core_reset_q <= core_reset_n;
        end
    end

    // Valid bits hide stale RAM contents from a previous image.
    always_ff @(posedge clock) begin
        if (clear) begin
            valid_bits <= '0;
        end else if (wr_en) begin
            valid_bits[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_idx] <= merged;
        end
    end

    assign rd_idx      = raddr[ADDR_SIZE-1:0];
    assign rd_in_range = (raddr[31:ADDR_SIZE] == '0);

    always_comb begin
        instr = FILL_WORD;
        if (state == RUN && rd_in_range && valid_bits[rd_idx]) begin
            instr = mem[rd_idx];
        end
    end

    assign load_ready = (state == LOAD);
    assign loaded     = (state == RUN);
    assign overflow   = (state == OVF);
    assign core_reset = core_reset_q;
    assign word_count = wc;
    assign fsm_state  = state;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-depth instance and a 4-word
// instance for overflow / exact-fill corners.
module tb_imem_loader;

    localparam logic [31:0] FILL = 32'h0000000D;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        load_valid = 1'b0, load_last = 1'b0, reload = 1'b0;
    logic [7:0]  load_data = 8'h0;
    logic [31:0] raddr = 32'h0;
    logic        load_ready, core_reset, loaded, overflow;
    logic [31:0] instr;
    logic [6:0]  word_count;
    logic [1:0]  fsm_state;

    logic        s_valid = 1'b0, s_last = 1'b0, s_reload = 1'b0;
    logic [7:0]  s_data = 8'h0;
    logic [31:0] s_raddr = 32'h0;
    logic        s_ready, s_core_reset, s_loaded, s_overflow;
    logic [31:0] s_instr;
    logic [2:0]  s_word_count;
    logic [1:0]  s_fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    imem_loader #(.ADDR_SIZE(6), .FILL_WORD(FILL)) dut (
        .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_last(load_last), .reload(reload), .raddr(raddr),
        .instr(instr), .core_reset(core_reset), .loaded(loaded), .overflow(overflow),
        .word_count(word_count), .fsm_state(fsm_state)
    );

    imem_loader #(.ADDR_SIZE(2), .FILL_WORD(FILL)) dut_s (
        .clock(clock), .reset(reset), .load_valid(s_valid), .load_ready(s_ready),
        .load_data(s_data), .load_last(s_last), .reload(s_reload), .raddr(s_raddr),
        .instr(s_instr), .core_reset(s_core_reset), .loaded(s_loaded), .overflow(s_overflow),
        .word_count(s_word_count), .fsm_state(s_fsm_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One byte handshake; inputs change only at the negedge, outputs are read #1 after the posedge.
    task automatic send(input bit sel, input logic [7:0] d, input bit last);
        @(negedge clock);
        if (sel) begin
            s_valid = 1'b1; s_data = d; s_last = last;
        end else begin
            load_valid = 1'b1; load_data = d; load_last = last;
        end
        @(posedge clock);
        #1;
        s_valid = 1'b0; s_last = 1'b0;
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_reload(input bit sel);
        @(negedge clock);
        if (sel) s_reload = 1'b1; else reload = 1'b1;
        @(posedge clock);
        #1;
        s_reload = 1'b0; reload = 1'b0;
    endtask

    task automatic check_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        raddr = a;
        #1;
        check(tag, instr, exp);
    endtask

    task automatic check_rd_s(input string tag, input logic [31:0] a, input logic [31:0] exp);
        s_raddr = a;
        #1;
        check(tag, s_instr, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_ready", {31'h0, load_ready}, 32'h1);
        check("rst_core_reset", {31'h0, core_reset}, 32'h1);
        check("rst_loaded", {31'h0, loaded}, 32'h0);
        check("rst_overflow", {31'h0, overflow}, 32'h0);
        check("rst_word_count", {25'h0, word_count}, 32'h0);
        check("rst_s_word_count", {29'h0, s_word_count}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        idle(1);
        check("post_rst_ready", {31'h0, load_ready}, 32'h1);

        // two-word image
        send(0, 8'h13, 0); send(0, 8'h00, 0); send(0, 8'h00, 0); send(0, 8'h20, 0);
        check("img1_wc_mid", {25'h0, word_count}, 32'h1);
        check_rd("img1_rd_during_load", 32'h0, FILL);
        send(0, 8'h0D, 0); send(0, 8'h00, 0); send(0, 8'h00, 0); send(0, 8'h00, 1);
        check("img1_loaded", {31'h0, loaded}, 32'h1);
        check("img1_core_reset_hold", {31'h0, core_reset}, 32'h1);
        check("img1_ready_low", {31'h0, load_ready}, 32'h0);
        check("img1_wc", {25'h0, word_count}, 32'h2);
        idle(1);
        check("img1_core_reset_fall", {31'h0, core_reset}, 32'h0);
        check_rd("img1_rd0", 32'h0, 32'h20000013);
        check_rd("img1_rd1", 32'h1, 32'h0000000D);
        check_rd("img1_rd2", 32'h2, FILL);
        check_rd("img1_rd_alias64", 32'h40, FILL);
        check_rd("img1_rd_high", 32'h1000_0000, FILL);

        // partial final word
        pulse_reload(0);
        check("rl1_core_reset", {31'h0, core_reset}, 32'h1);
        check("rl1_wc", {25'h0, word_count}, 32'h0);
        check("rl1_ready", {31'h0, load_ready}, 32'h1);
        check_rd("rl1_rd0", 32'h0, FILL);
        send(0, 8'hAA, 0); send(0, 8'hBB, 0); send(0, 8'hCC, 0); send(0, 8'hDD, 0);
        send(0, 8'h11, 1);
        check("part_wc", {25'h0, word_count}, 32'h2);
        idle(1);
        check_rd("part_rd0", 32'h0, 32'hDDCCBBAA);
        check_rd("part_rd1", 32'h1, 32'h00000011);

        // backpressure: random idle gaps over a 3-word image
        pulse_reload(0);
        for (int i = 0; i < 12; i++) begin
            idle($urandom_range(0, 3));
            send(0, 8'(i + 1), i == 11);
        end
        check("gap_wc", {25'h0, word_count}, 32'h3);
        check_rd("gap_rd0", 32'h0, 32'h04030201);
        check_rd("gap_rd1", 32'h1, 32'h08070605);
        check_rd("gap_rd2", 32'h2, 32'h0C0B0A09);
        send(0, 8'hEE, 1);
        check("run_ignore_wc", {25'h0, word_count}, 32'h3);
        check("run_ignore_ready", {31'h0, load_ready}, 32'h0);
        check_rd("run_ignore_rd0", 32'h0, 32'h04030201);

        // reload in RUN, then a one-word image B
        pulse_reload(0);
        check("rl2_core_reset", {31'h0, core_reset}, 32'h1);
        check("rl2_loaded", {31'h0, loaded}, 32'h0);
        for (int i = 0; i < 4; i++) check_rd("rl2_rd_fill", 32'(i), FILL);
        send(0, 8'h44, 0); send(0, 8'h33, 0); send(0, 8'h22, 0); send(0, 8'h11, 1);
        idle(1);
        check_rd("imgb_rd0", 32'h0, 32'h11223344);
        check_rd("imgb_rd1_stale", 32'h1, FILL);
        check_rd("imgb_rd2_stale", 32'h2, FILL);

        // reload coincident with a byte handshake discards that byte
        pulse_reload(0);
        @(negedge clock);
        load_valid = 1'b1; load_data = 8'h55; reload = 1'b1;
        @(posedge clock);
        #1;
        load_valid = 1'b0; reload = 1'b0;
        check("rl3_wc", {25'h0, word_count}, 32'h0);
        send(0, 8'h66, 1);
        idle(1);
        check_rd("rl3_rd0", 32'h0, 32'h00000066);

        // reset mid-load
        pulse_reload(0);
        for (int i = 0; i < 6; i++) send(0, 8'h90 + 8'(i), 0);
        check("midrst_wc_before", {25'h0, word_count}, 32'h1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midrst_wc", {25'h0, word_count}, 32'h0);
        check("midrst_ready", {31'h0, load_ready}, 32'h1);
        check("midrst_core_reset", {31'h0, core_reset}, 32'h1);
        @(negedge clock);
        reset = 1'b0;
        send(0, 8'h7F, 1);
        idle(1);
        check_rd("midrst_rd0", 32'h0, 32'h0000007F);

        // overflow on the 4-word instance
        for (int i = 0; i < 16; i++) send(1, 8'h10 + 8'(i), 0);
        check("ovf_wc_full", {29'h0, s_word_count}, 32'h4);
        check("ovf_pre_flag", {31'h0, s_overflow}, 32'h0);
        check("ovf_pre_ready", {31'h0, s_ready}, 32'h1);
        send(1, 8'hFF, 0);
        check("ovf_flag", {31'h0, s_overflow}, 32'h1);
        check("ovf_ready", {31'h0, s_ready}, 32'h0);
        check("ovf_wc_hold", {29'h0, s_word_count}, 32'h4);
        idle(2);
        check("ovf_core_reset", {31'h0, s_core_reset}, 32'h1);
        check("ovf_loaded", {31'h0, s_loaded}, 32'h0);
        check_rd_s("ovf_rd0", 32'h0, FILL);

        // exact fill on the 4-word instance
        pulse_reload(1);
        check("s_rl_overflow", {31'h0, s_overflow}, 32'h0);
        check("s_rl_ready", {31'h0, s_ready}, 32'h1);
        for (int i = 0; i < 16; i++) send(1, 8'h10 + 8'(i), i == 15);
        check("fill_overflow", {31'h0, s_overflow}, 32'h0);
        check("fill_loaded", {31'h0, s_loaded}, 32'h1);
        check("fill_wc", {29'h0, s_word_count}, 32'h4);
        idle(1);
        check("fill_core_reset", {31'h0, s_core_reset}, 32'h0);
        check_rd_s("fill_rd0", 32'h0, 32'h13121110);
        check_rd_s("fill_rd3", 32'h3, 32'h1F1E1D1C);
        check_rd_s("fill_rd4_alias", 32'h4, FILL);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
